// File: rtl/sap_mem_arbiter_if.sv
// Bundle of the CPU port, the loader port and the RAM-side signals of the
// SAP memory arbiter. The slave modport is the arbiter's view. The master
// modport is the environment's view: both requesters plus the RAM primitive.
interface sap_mem_arbiter_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_stall;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;

    logic              ld_req;
    logic              ld_we;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_wdata;
    logic              ld_gnt;
    logic              ld_rvalid;
    logic [DATA_W-1:0] ld_rdata;
    logic              ld_lock;
    logic              locked;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
        input  ld_req, ld_we, ld_addr, ld_wdata, ld_lock,
        output ld_gnt, ld_rvalid, ld_rdata, locked,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
        output ld_req, ld_we, ld_addr, ld_wdata, ld_lock,
        input  ld_gnt, ld_rvalid, ld_rdata, locked,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/sap_mem_arbiter.sv
// Shares the single-port SAP RAM between the CPU datapath and the program
// loader. The CPU normally wins. A saturating counter of consecutive loader
// denials forces the loader ahead once it reaches STARVE_MAX, and the loader
// can lock the RAM for a burst, which stalls the CPU until the lock drops.
// Reads return one cycle after the grant, routed by a one-deep tag.
module sap_mem_arbiter #(
    parameter int ADDR_W     = 4,
    parameter int DATA_W     = 8,
    parameter int STARVE_MAX = 3
) (
    input  logic               clk,
    input  logic               reset,
    sap_mem_arbiter_if.slave   bus
);

    typedef enum logic {
        CPU_PRI   = 1'b0,
        LD_LOCKED = 1'b1
    } state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [3:0]        r_starve;
    logic [3:0]        w_starve_nxt;
    logic              r_tag_rd;
    logic              r_tag_port;
    logic              w_cpu_gnt;
    logic              w_ld_gnt;
    logic              w_starved;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_wdata;
    logic              w_cpu_rvalid;
    logic              w_ld_rvalid;

    assign w_starved = (r_starve == STARVE_LIM);

    // Grant decision and next state; reset blocks every grant in its cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_cpu_gnt   = 1'b0;
        w_ld_gnt    = 1'b0;
        if (!reset) begin
            case (r_state)
                CPU_PRI: begin
                    if (bus.ld_req && (!bus.cpu_req || w_starved)) begin
                        w_ld_gnt = 1'b1;
                    end else if (bus.cpu_req) begin
                        w_cpu_gnt = 1'b1;
                    end
                    // Lock only takes effect when it rides on a loader grant.
                    if (w_ld_gnt && bus.ld_lock) begin
                        w_state_nxt = LD_LOCKED;
                    end
                end
                LD_LOCKED: begin
                    w_ld_gnt = bus.ld_req;
                    if (!bus.ld_lock) begin
                        w_state_nxt = CPU_PRI;
                    end
                end
                default: w_state_nxt = CPU_PRI;
            endcase
        end
    end

    // Starvation counter: counts consecutive denied loader requests in
    // CPU_PRI; any grant, idle loader or lock entry brings it back to zero.
    always_comb begin
        w_starve_nxt = 4'd0;
        if (r_state == CPU_PRI && bus.ld_req && !w_ld_gnt) begin
            w_starve_nxt = w_starved ? r_starve : r_starve + 4'd1;
        end
    end

    // State, counter and read-return tag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= CPU_PRI;
            r_starve   <= 4'd0;
            r_tag_rd   <= 1'b0;
            r_tag_port <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_starve   <= w_starve_nxt;
            r_tag_rd   <= (w_cpu_gnt && !bus.cpu_we) || (w_ld_gnt && !bus.ld_we);
            r_tag_port <= w_ld_gnt;
        end
    end

    // RAM mux: the granted port drives the RAM, otherwise everything idles at 0.
    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_addr  = '0;
        w_mem_wdata = '0;
        if (w_cpu_gnt) begin
            w_mem_we    = bus.cpu_we;
            w_mem_addr  = bus.cpu_addr;
            w_mem_wdata = bus.cpu_wdata;
        end else if (w_ld_gnt) begin
            w_mem_we    = bus.ld_we;
            w_mem_addr  = bus.ld_addr;
            w_mem_wdata = bus.ld_wdata;
        end
    end

    assign bus.mem_en    = w_cpu_gnt | w_ld_gnt;
    assign bus.mem_we    = w_mem_we;
    assign bus.mem_addr  = w_mem_addr;
    assign bus.mem_wdata = w_mem_wdata;

    assign bus.cpu_gnt   = w_cpu_gnt;
    assign bus.ld_gnt    = w_ld_gnt;
    assign bus.cpu_stall = bus.cpu_req & ~w_cpu_gnt;
    assign bus.locked    = (r_state == LD_LOCKED);

    // A reset in the return cycle drops the pending read rather than delivering it.
    assign w_cpu_rvalid  = r_tag_rd & ~r_tag_port & ~reset;
    assign w_ld_rvalid   = r_tag_rd &  r_tag_port & ~reset;

    assign bus.cpu_rvalid = w_cpu_rvalid;
    assign bus.ld_rvalid  = w_ld_rvalid;
    assign bus.cpu_rdata  = w_cpu_rvalid ? bus.mem_rdata : '0;
    assign bus.ld_rdata   = w_ld_rvalid  ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_sap_mem_arbiter.sv
// Bench for sap_mem_arbiter: directed scenarios followed by random traffic,
// checked cycle by cycle against a rule-level model of the arbiter and a
// shadow copy of the RAM contents.
module tb_sap_mem_arbiter;

    localparam int ADDR_W     = 4;
    localparam int DATA_W     = 8;
    localparam int STARVE_MAX = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    sap_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    sap_mem_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // RAM primitive: synchronous single port, read data valid the next cycle.
    logic [7:0] ram [16];
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata     <= ram[bus.mem_addr];
        end
    end

    int errors = 0;
    int checks = 0;

    // Reference model state.
    bit         m_known = 1'b0;
    bit         m_locked = 1'b0;
    int         m_denied = 0;
    bit         m_pend = 1'b0;
    bit         m_pend_ld = 1'b0;
    logic [7:0] m_pend_data = 8'h00;
    logic [7:0] shadow [16];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive after the falling edge, check mid-cycle,
    // then advance the model to what the next rising edge produces.
    task automatic step(input bit rs,
                        input bit cr, input bit cw, input logic [3:0] ca, input logic [7:0] cd,
                        input bit lr, input bit lw, input logic [3:0] la, input logic [7:0] ld,
                        input bit lk);
        int g;
        bit exp_crv;
        bit exp_lrv;
        @(negedge clk);
        reset         = rs;
        bus.cpu_req   = cr;
        bus.cpu_we    = cw;
        bus.cpu_addr  = ca;
        bus.cpu_wdata = cd;
        bus.ld_req    = lr;
        bus.ld_we     = lw;
        bus.ld_addr   = la;
        bus.ld_wdata  = ld;
        bus.ld_lock   = lk;
        #1;
        // 0 = nobody, 1 = CPU, 2 = loader
        g = 0;
        if (!rs) begin
            if (m_locked)        g = lr ? 2 : 0;
            else if (cr && lr)   g = (m_denied >= STARVE_MAX) ? 2 : 1;
            else if (cr)         g = 1;
            else if (lr)         g = 2;
        end
        exp_crv = m_pend && !m_pend_ld && !rs;
        exp_lrv = m_pend &&  m_pend_ld && !rs;
        check("cpu_gnt",    bus.cpu_gnt,    32'(g == 1));
        check("ld_gnt",     bus.ld_gnt,     32'(g == 2));
        check("cpu_stall",  bus.cpu_stall,  32'(cr && g != 1));
        check("mem_en",     bus.mem_en,     32'(g != 0));
        check("mem_we",     bus.mem_we,     32'(g == 1 ? cw : (g == 2 ? lw : 1'b0)));
        check("mem_addr",   bus.mem_addr,   32'(g == 1 ? ca : (g == 2 ? la : 4'h0)));
        check("mem_wdata",  bus.mem_wdata,  32'(g == 1 ? cd : (g == 2 ? ld : 8'h00)));
        if (m_known) check("locked", bus.locked, 32'(m_locked));
        check("cpu_rvalid", bus.cpu_rvalid, 32'(exp_crv));
        check("ld_rvalid",  bus.ld_rvalid,  32'(exp_lrv));
        check("cpu_rdata",  bus.cpu_rdata,  32'(exp_crv ? m_pend_data : 8'h00));
        check("ld_rdata",   bus.ld_rdata,   32'(exp_lrv ? m_pend_data : 8'h00));
        if (rs) begin
            m_known  = 1'b1;
            m_locked = 1'b0;
            m_denied = 0;
            m_pend   = 1'b0;
        end else begin
            m_pend = 1'b0;
            if (g == 1) begin
                if (cw) shadow[ca] = cd;
                else begin m_pend = 1'b1; m_pend_ld = 1'b0; m_pend_data = shadow[ca]; end
            end else if (g == 2) begin
                if (lw) shadow[la] = ld;
                else begin m_pend = 1'b1; m_pend_ld = 1'b1; m_pend_data = shadow[la]; end
            end
            if (!m_locked && lr && g != 2)
                m_denied = (m_denied < STARVE_MAX) ? m_denied + 1 : m_denied;
            else
                m_denied = 0;
            if (m_locked) m_locked = lk;
            else          m_locked = (g == 2) && lk;
        end
    endtask

    task automatic idle();
        step(0, 0, 0, 4'h0, 8'h00, 0, 0, 4'h0, 8'h00, 0);
    endtask

    initial begin
        logic [7:0] pat;
        logic [7:0] d;
        bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.ld_req = 0;  bus.ld_we = 0;  bus.ld_addr = '0;  bus.ld_wdata = '0;
        bus.ld_lock = 0;

        // Reset with both requesters active.
        step(1, 1, 0, 4'h1, 8'h00, 1, 0, 4'h2, 8'h00, 1);
        step(1, 1, 0, 4'h1, 8'h00, 1, 0, 4'h2, 8'h00, 1);
        check("rst_locked", bus.locked, 32'd0);

        // Fill the RAM through the loader; address 5 gets 0x3C.
        for (int a = 0; a < 16; a++) begin
            d = (a == 5) ? 8'h3C : 8'($urandom);
            step(0, 0, 0, 4'h0, 8'h00, 1, 1, 4'(a), d, 0);
        end

        // Uncontested CPU read of address 5.
        step(0, 1, 0, 4'h5, 8'h00, 0, 0, 4'h0, 8'h00, 0);
        idle();
        check("cpu_read5", bus.cpu_rdata, 32'h3C);

        // Starvation: both reading every cycle.
        pat = 8'b1000_1000;
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 0, 4'(i), 8'h00, 1, 0, 4'(15 - i), 8'h00, 0);
            check("starve_pattern", bus.ld_gnt, 32'(pat[i]));
        end
        idle();

        // Three CPU wins build up starvation, then the loader's locked burst.
        for (int i = 0; i < 3; i++)
            step(0, 1, 0, 4'h2, 8'h00, 1, 1, 4'h2, 8'hA5, 1);
        for (int k = 0; k < 16; k++) begin
            d = (k == 0) ? 8'hA5 : 8'($urandom);
            step(0, 1, 0, 4'h2, 8'h00, 1, 1, 4'((2 + k) % 16), d, 1);
            check("lock_stall", bus.cpu_stall, 32'd1);
        end
        // Lock released on this edge; CPU still stalled in this cycle.
        step(0, 1, 0, 4'h2, 8'h00, 0, 0, 4'h0, 8'h00, 0);
        // Loader competes right after release and loses.
        step(0, 1, 0, 4'h2, 8'h00, 1, 0, 4'h9, 8'h00, 0);
        check("unlock_cpu_gnt", bus.cpu_gnt, 32'd1);
        idle();
        check("unlock_read2", bus.cpu_rdata, 32'hA5);

        // Reset in the return cycle of a loader read.
        step(0, 0, 0, 4'h0, 8'h00, 1, 0, 4'h7, 8'h00, 0);
        step(1, 0, 0, 4'h0, 8'h00, 0, 0, 4'h0, 8'h00, 0);
        check("rst_mid_read_rv", bus.ld_rvalid, 32'd0);
        step(0, 1, 0, 4'h3, 8'h00, 1, 0, 4'h4, 8'h00, 0);
        check("post_rst_cpu_pri", bus.cpu_gnt, 32'd1);
        idle();

        // Alternating back-to-back reads.
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) step(0, 1, 0, 4'(i), 8'h00, 0, 0, 4'h0, 8'h00, 0);
            else            step(0, 0, 0, 4'h0, 8'h00, 1, 0, 4'(i + 8), 8'h00, 0);
        end
        idle();

        // Random traffic.
        for (int i = 0; i < 500; i++) begin
            step(($urandom_range(0, 59) == 0),
                 1'($urandom), 1'($urandom), 4'($urandom), 8'($urandom),
                 1'($urandom), 1'($urandom), 4'($urandom), 8'($urandom),
                 ($urandom_range(0, 3) == 0));
        end
        step(0, 0, 0, 4'h0, 8'h00, 0, 0, 4'h0, 8'h00, 0);
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sap_mem_arbiter.md
# sap_mem_arbiter

Two-port arbiter that shares the single-port 16x8 SAP program/data RAM between the CPU datapath (port 0, driven by the control-logic memory micro-steps MI/RO/RI) and the program loader (port 1, switch/UART loader and debug reads). It sits between both requesters and the RAM primitive:
- CPU has priority by default, with a starvation guard for the loader.
- The loader can lock the RAM for a burst, which stalls the CPU.

## Interface
Parameters:
- ADDR_W, 4, RAM address width
- DATA_W, 8, RAM data width
- STARVE_MAX, 3, consecutive denied loader cycles before the loader is forced ahead of the CPU (1..15)

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  reset, synchronous, active-high
- cpu_req  in  1  CPU access request, held until granted
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_gnt  out  1  access accepted this cycle
- cpu_stall  out  1  cpu_req & ~cpu_gnt; control logic holds its micro-step
- cpu_rvalid  out  1  read data valid, one cycle after a granted read
- cpu_rdata  out  DATA_W  read data
- ld_req, ld_we, ld_addr, ld_wdata, ld_gnt, ld_rvalid, ld_rdata: loader equivalents of the cpu_* signals, same widths and meanings
- ld_lock  in  1  loader requests exclusive ownership while high
- locked  out  1  arbiter is in LD_LOCKED
- mem_en  out  1  RAM access strobe
- mem_we  out  1  RAM write enable
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data, valid the cycle after mem_en & ~mem_we

## Operation
- **States.**
  - CPU_PRI: reset state.
  - LD_LOCKED.
- **Grant in CPU_PRI.** Combinational, at most one grant per cycle.
  - Only one requester: that requester is granted.
  - Both requesting: CPU wins, unless starve_cnt == STARVE_MAX, in which case the loader wins.
- **Grant in LD_LOCKED.**
  - The loader is granted whenever ld_req = 1.
  - cpu_gnt is held at 0, so cpu_stall = cpu_req.
- **Transitions.**
  - CPU_PRI -> LD_LOCKED on an edge where ld_gnt = 1 and ld_lock = 1.
  - LD_LOCKED -> CPU_PRI on the first edge where ld_lock = 0.
  - ld_lock is ignored unless it accompanies a loader grant.
- **starve_cnt.** Saturating at STARVE_MAX.
  - Increments on each edge in CPU_PRI with ld_req = 1 and ld_gnt = 0.
  - Clears on ld_gnt = 1, on ld_req = 0, or on entry to LD_LOCKED.
- **RAM mux.**
  - mem_en = cpu_gnt | ld_gnt.
  - mem_we, mem_addr and mem_wdata are taken from the granted port (combinational).
  - With no grant, mem_we = 0 and addr/wdata = 0.
- **Read return.**
  - A registered 2-bit tag records {port, read} for the granted access.
  - Next cycle, the tagged port's rvalid pulses for one cycle and its rdata = mem_rdata.
  - The other port's rdata is 0.
- **Writes.** Complete at the grant edge. No rvalid is generated.
- **Back-to-back reads.** Permitted every cycle; the tag pipeline is one deep and is overwritten each cycle.

## Timing
- **Reset.** While reset = 1 at an edge:
  - state := CPU_PRI, starve_cnt := 0, tag cleared.
  - All grants and mem_en are forced to 0 that cycle.
- **After reset (first cycle).**
  - cpu_rvalid = ld_rvalid = 0.
  - locked = 0.
  - rdata outputs = 0.
- **Latency.**
  - Grant: 0 cycles from request when uncontested.
  - Read data: 1 cycle after the grant.
- **Reset mid-read.** Reset asserted in the cycle after a granted read suppresses that rvalid. The read is dropped, not replayed.
- **Contested timing, STARVE_MAX = 3, CPU requesting continuously.**
  - Loader denied at cycles t, t+1, t+2.
  - Loader granted at t+3.
  - CPU is stalled at t+3 only.
- **Lock release.**
  - ld_lock = 0 at edge e: CPU is grantable in the cycle after e.
  - A loader request in that same cycle loses to the CPU, since starve_cnt = 0.
- **Simultaneous events.**
  - A loader grant carrying ld_lock, with cpu_req also high: the CPU is denied this cycle and stalled until unlock.
  - Requester changing addr/we while not granted: allowed. The value present in the grant cycle is used.

## Test plan
- **Reset.** Reset for 2 cycles with both reqs high -> no grants, mem_en = 0, all rvalid = 0, locked = 0.
- **Uncontested CPU read.** RAM[5] = 0x3C, CPU read addr 5 -> cpu_gnt same cycle, mem_addr = 5; next cycle cpu_rvalid = 1, cpu_rdata = 0x3C, ld_rvalid = 0.
- **Starvation.** Both requesting continuously, STARVE_MAX = 3 -> grant pattern CPU,CPU,CPU,LD,CPU,CPU,CPU,LD.
- **Loader lock.** Loader write 0xA5 to addr 2 with ld_lock = 1, then 15 more locked writes, CPU requesting throughout -> cpu_gnt = 0 and cpu_stall = 1 for all 16 cycles. Release ld_lock -> CPU granted on the next cycle; a CPU read of addr 2 returns 0xA5.
- **Reset mid-read.** Reset asserted in the cycle after a granted loader read -> ld_rvalid stays 0, state CPU_PRI.
- **Alternating traffic.** Back-to-back alternating CPU/loader reads on different addresses -> each rvalid lands on the correct port with that port's data, one cycle after its grant.
